// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared op encodings, FSM state type and op-decode helpers
//               for the multicycle multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    ZERO = 3'd4
  } md_state_t;

  function automatic logic md_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_signfix.sv
// ============================================================================
// Module      : muldiv_signfix
// Description : Conditional two's-complement negation (combinational).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  output logic [WIDTH-1:0] result
);

  assign result = neg ? (~value + WIDTH'(1)) : value;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module      : muldiv_unit
// Description : Multicycle shift-add multiplier / restoring divider with
//               HI/LO result registers and start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             ovf,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t          r_state;
  md_state_t          w_next;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_m;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_qsign;
  logic               r_rsign;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dz;
  logic               r_ovf;

  logic               w_sgn;
  logic               w_div;
  logic               w_fin;
  logic               w_zero;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH+1:0]   w_diff;
  logic               w_fits;
  logic               w_mul_ovf;
  logic               w_min_neg;

  assign w_sgn = md_is_signed(r_op);
  assign w_div = md_is_div(r_op);

  muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (
    .value(r_a), .neg(w_sgn & r_a[WIDTH-1]), .result(w_abs_a));
  muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (
    .value(r_b), .neg(w_sgn & r_b[WIDTH-1]), .result(w_abs_b));
  muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .value(r_acc), .neg(r_qsign), .result(w_prod));
  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_quo (
    .value(r_acc[WIDTH-1:0]), .neg(r_qsign), .result(w_quo));
  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (
    .value(r_rem[WIDTH-1:0]), .neg(r_rsign), .result(w_rem));

  // Multiply step: conditionally add multiplicand into the upper half, shift right.
  assign w_add = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_m : '0)};

  // Divide step: restoring subtraction of the divisor from the shifted remainder.
  assign w_trial = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
  assign w_diff  = {1'b0, w_trial} - {2'b00, r_m};
  assign w_fits  = r_rem[WIDTH] | ~w_diff[WIDTH+1];

  assign w_mul_ovf = w_sgn ? (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}})
                           : (w_prod[2*WIDTH-1:WIDTH] != '0);
  assign w_min_neg = w_sgn && (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (r_b == '1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = (md_is_div(op) && (b == '0)) ? ZERO : PREP;
      PREP: w_next = RUN;
      RUN:  if (r_cnt == '0) w_next = FIX;
      FIX:  w_next = IDLE;
      ZERO: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (r_state != IDLE);
    w_fin  = (r_state == FIX) || (r_state == ZERO);
    w_zero = (r_state == ZERO);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_m     <= '0;
      r_acc   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_qsign <= 1'b0;
      r_rsign <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= w_fin;
      r_dz   <= w_zero;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op  <= op;
            r_a   <= a;
            r_b   <= b;
            r_ovf <= 1'b0;
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        PREP: begin
          r_qsign <= w_sgn & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_rsign <= w_sgn & r_a[WIDTH-1];
          r_cnt   <= CNT_W'(WIDTH-1);
          r_rem   <= '0;
          if (w_div) begin
            r_m   <= w_abs_b;
            r_acc <= {{WIDTH{1'b0}}, w_abs_a};
          end else begin
            r_m   <= w_abs_a;
            r_acc <= {{WIDTH{1'b0}}, w_abs_b};
          end
        end
        RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_div) begin
            r_rem              <= w_fits ? w_diff[WIDTH:0] : w_trial;
            r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], w_fits};
          end else begin
            r_acc <= {w_add, r_acc[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (w_div) begin
            r_hi  <= w_rem;
            r_lo  <= w_quo;
            r_ovf <= w_min_neg;
          end else begin
            r_hi  <= w_prod[2*WIDTH-1:WIDTH];
            r_lo  <= w_prod[WIDTH-1:0];
            r_ovf <= w_mul_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign done     = r_done;
  assign div_zero = r_dz;
  assign ovf      = r_ovf;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        ovf;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  int          lat;
  int          bcnt;
  int          ndone;
  logic        dz;
  logic [31:0] rhi;
  logic [31:0] rlo;
  logic        rovf;
  logic        rovf_held;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_zero(div_zero), .ovf(ovf), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one op; optionally inject a second start + hi_we at busy cycle inj.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic hwe, input int inj);
    op = o; a = x; b = y; start = 1'b1; hi_we = hwe; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; a = 32'h5A5A_5A5A; b = 32'hA5A5_A5A5;
    lat = 0; bcnt = 0; ndone = 0; dz = 1'b0; rhi = '0; rlo = '0; rovf = 1'b0;
    for (int i = 1; i <= 60 && lat == 0; i++) begin
      if (busy) bcnt++;
      if (inj != 0 && i == inj) begin
        start = 1'b1; op = MD_MULTU; a = 32'd9; b = 32'd9; hi_we = 1'b1;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        lat = i; ndone = 1; dz = div_zero; rhi = hi; rlo = lo; rovf = ovf;
      end
    end
    start = 1'b0; hi_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    rovf_held = ovf;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = MD_MULT; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_ovf_dz", {ovf, div_zero}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    do_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 0);
    chk("mult_lat", lat, 34);
    chk("mult_busy_cycles", bcnt, 34);
    chk("mult_ndone", ndone, 1);
    chk("mult_hi", rhi, 32'hFFFF_FFFF);
    chk("mult_lo", rlo, 32'hFFFF_FFEB);
    chk("mult_ovf", rovf, 0);
    chk("mult_dz", dz, 0);

    do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    chk("multu_hi", rhi, 32'hFFFF_FFFE);
    chk("multu_lo", rlo, 32'h0000_0001);
    chk("multu_ovf", rovf, 1);
    chk("multu_ovf_held", rovf_held, 1);

    do_op(MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    chk("mult_m1_hi", rhi, 32'h0);
    chk("mult_m1_lo", rlo, 32'h1);
    chk("mult_m1_ovf", rovf, 0);

    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    chk("div_lat", lat, 34);
    chk("div_lo", rlo, 32'hFFFF_FFFD);
    chk("div_hi", rhi, 32'hFFFF_FFFF);
    chk("div_ovf", rovf, 0);

    do_op(MD_DIVU, 32'd7, 32'd2, 1'b0, 0);
    chk("divu_lo", rlo, 32'd3);
    chk("divu_hi", rhi, 32'd1);

    hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
    @(posedge clk); #1;
    lo_we = 1'b0;
    chk("mthi", hi, 32'h1234);
    chk("mtlo", lo, 32'h5678);

    do_op(MD_DIV, 32'd5, 32'd0, 1'b0, 0);
    chk("dz_lat", lat, 1);
    chk("dz_flag", dz, 1);
    chk("dz_ndone", ndone, 1);
    chk("dz_hi", rhi, 32'h1234);
    chk("dz_lo", rlo, 32'h5678);
    chk("dz_ovf", rovf, 0);

    do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    chk("minneg_lo", rlo, 32'h8000_0000);
    chk("minneg_hi", rhi, 32'h0);
    chk("minneg_ovf", rovf, 1);

    do_op(MD_MULTU, 32'd2, 32'd3, 1'b1, 0);
    chk("start_wins_hi", rhi, 32'h0);
    chk("start_wins_lo", rlo, 32'd6);

    do_op(MD_MULT, 32'd5, 32'd6, 1'b0, 10);
    chk("restart_lat", lat, 34);
    chk("restart_ndone", ndone, 1);
    chk("restart_hi", rhi, 32'h0);
    chk("restart_lo", rlo, 32'd30);

    op = MD_MULTU; a = 32'h1234_5678; b = 32'h10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("pre_abort_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    do_op(MD_DIVU, 32'd100, 32'd7, 1'b0, 0);
    chk("post_lo", rlo, 32'd14);
    chk("post_hi", rhi, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
